// File: rtl/clock_time_ctrl_pkg.sv
// Shared definitions for the clock time controller: mode codes, BCD moduli,
// default beep durations and the BCD increment helper.
package clock_time_pkg;

  typedef enum logic [2:0] {
    MODE_RUN   = 3'd0,
    MODE_SET_H = 3'd1,
    MODE_SET_M = 3'd2,
    MODE_AL_H  = 3'd3,
    MODE_AL_M  = 3'd4
  } mode_e;

  localparam logic [2:0] ST_RUN   = MODE_RUN;
  localparam logic [2:0] ST_SET_H = MODE_SET_H;
  localparam logic [2:0] ST_SET_M = MODE_SET_M;
  localparam logic [2:0] ST_AL_H  = MODE_AL_H;
  localparam logic [2:0] ST_AL_M  = MODE_AL_M;

  localparam int unsigned MOD_HOUR       = 24;
  localparam int unsigned MOD_MIN_SEC    = 60;
  localparam int unsigned CHIME_SECS_DEF = 2;
  localparam int unsigned ALARM_SECS_DEF = 30;

  // Two-digit BCD increment that wraps to 00 after modulus-1.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input int unsigned modulus);
    logic [7:0] last;
    last = {4'((modulus - 1) / 10), 4'((modulus - 1) % 10)};
    if (v == last) return 8'h00;
    if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

endpackage

// File: rtl/clock_time_ctrl_if.sv
// Pulse inputs and display/beeper outputs of the clock time controller.
// The controller takes the slave side; the driver of ticks and keys takes master.
interface clock_time_ctrl_if;
  logic       tick_1hz;
  logic       tick_2hz;
  logic       key_mode;
  logic       key_inc;
  logic [7:0] hour;
  logic [7:0] min;
  logic [7:0] sec;
  logic [2:0] mode;
  logic [2:0] blink_mask;
  logic       beep_en;

  modport master (
    output tick_1hz, tick_2hz, key_mode, key_inc,
    input  hour, min, sec, mode, blink_mask, beep_en
  );

  modport slave (
    input  tick_1hz, tick_2hz, key_mode, key_inc,
    output hour, min, sec, mode, blink_mask, beep_en
  );
endinterface

// File: rtl/clock_time_ctrl_bcd_mod_counter.sv
// Two-digit BCD counter with programmable modulus, increment enable,
// synchronous clear (dominant), wrap carry and look-ahead next value.
module bcd_mod_counter
  import clock_time_pkg::*;
#(
  parameter int unsigned MODULUS = 60,
  parameter logic [7:0]  RST_VAL = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       inc_i,
  input  logic       clr_i,
  output logic [7:0] val_o,
  output logic [7:0] nxt_o,
  output logic       carry_o
);

  logic [7:0] val_q, val_d;

  always_comb begin
    val_d = val_q;
    if (clr_i)      val_d = 8'h00;
    else if (inc_i) val_d = bcd_inc(val_q, MODULUS);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) val_q <= RST_VAL;
    else     val_q <= val_d;
  end

  assign val_o   = val_q;
  assign nxt_o   = val_d;
  assign carry_o = inc_i && !clr_i && (val_d == 8'h00);

endmodule

// File: rtl/clock_time_ctrl.sv
// Time-keeping and setting controller for a 24-hour BCD clock with hourly chime.
// Define ALARM_EN to add alarm-setting states, alarm registers and the alarm trigger.
module clock_time_ctrl
  import clock_time_pkg::*;
#(
  parameter int unsigned CHIME_SECS = CHIME_SECS_DEF,
  parameter int unsigned ALARM_SECS = ALARM_SECS_DEF
) (
  input logic              clk,
  input logic              reset,
  clock_time_ctrl_if.slave bus
);

  localparam int unsigned BEEP_MAX = (ALARM_SECS > CHIME_SECS) ? ALARM_SECS : CHIME_SECS;
  localparam int unsigned BEEP_W   = $clog2(BEEP_MAX + 1);

  logic [2:0]        mode_q, mode_d;
  logic              blink_q, blink_d;
  logic [2:0]        mask_q, mask_d;
  logic [BEEP_W-1:0] beep_q, beep_d;

  logic beep_on, consume, mode_adv, inc_ok, running, count_en;
  logic chime_hit, alarm_hit;
  logic sec_inc, sec_clr, min_inc, hour_inc;
  logic [7:0] sec_v, min_v, hour_v, sec_nxt, min_nxt, hour_nxt;
  logic sec_c, min_c, hour_c;
  logic unused_ok;

  // A key press while beeping only silences the beeper; key_mode beats key_inc.
  assign beep_on  = (beep_q != '0);
  assign consume  = (bus.key_mode || bus.key_inc) && beep_on;
  assign mode_adv = bus.key_mode && !consume;
  assign inc_ok   = bus.key_inc && !bus.key_mode && !consume;

`ifdef ALARM_EN
  assign running = mode_q inside {ST_RUN, ST_AL_H, ST_AL_M};
`else
  assign running = (mode_q == ST_RUN);
`endif
  assign count_en = bus.tick_1hz && running;

  assign sec_inc  = count_en;
  assign sec_clr  = mode_adv && (mode_q == ST_SET_M);
  assign min_inc  = (count_en && sec_c) || (inc_ok && (mode_q == ST_SET_M));
  assign hour_inc = (count_en && min_c) || (inc_ok && (mode_q == ST_SET_H));

  bcd_mod_counter #(.MODULUS(MOD_MIN_SEC), .RST_VAL(8'h00)) u_sec (
    .clk(clk), .rst(reset), .inc_i(sec_inc), .clr_i(sec_clr),
    .val_o(sec_v), .nxt_o(sec_nxt), .carry_o(sec_c));
  bcd_mod_counter #(.MODULUS(MOD_MIN_SEC), .RST_VAL(8'h00)) u_min (
    .clk(clk), .rst(reset), .inc_i(min_inc), .clr_i(1'b0),
    .val_o(min_v), .nxt_o(min_nxt), .carry_o(min_c));
  bcd_mod_counter #(.MODULUS(MOD_HOUR), .RST_VAL(8'h00)) u_hour (
    .clk(clk), .rst(reset), .inc_i(hour_inc), .clr_i(1'b0),
    .val_o(hour_v), .nxt_o(hour_nxt), .carry_o(hour_c));

  assign chime_hit = count_en && (mode_q == ST_RUN) && min_c;

`ifdef ALARM_EN
  logic [7:0] al_hour_v, al_min_v, al_hour_nxt, al_min_nxt;
  logic       al_hour_c, al_min_c, show_al;

  bcd_mod_counter #(.MODULUS(MOD_HOUR), .RST_VAL(8'h07)) u_al_hour (
    .clk(clk), .rst(reset), .inc_i(inc_ok && (mode_q == ST_AL_H)), .clr_i(1'b0),
    .val_o(al_hour_v), .nxt_o(al_hour_nxt), .carry_o(al_hour_c));
  bcd_mod_counter #(.MODULUS(MOD_MIN_SEC), .RST_VAL(8'h00)) u_al_min (
    .clk(clk), .rst(reset), .inc_i(inc_ok && (mode_q == ST_AL_M)), .clr_i(1'b0),
    .val_o(al_min_v), .nxt_o(al_min_nxt), .carry_o(al_min_c));

  // Match against the time this tick produces, so the beep starts with the rollover.
  assign alarm_hit = count_en && sec_c && (min_nxt == al_min_v) && (hour_nxt == al_hour_v);
  assign show_al   = (mode_q == ST_AL_H) || (mode_q == ST_AL_M);
  assign bus.hour  = show_al ? al_hour_v : hour_v;
  assign bus.min   = show_al ? al_min_v  : min_v;
  assign bus.sec   = show_al ? 8'h00     : sec_v;
  assign unused_ok = &{1'b0, hour_c, sec_nxt, al_hour_c, al_min_c, al_hour_nxt, al_min_nxt};
`else
  assign alarm_hit = 1'b0;
  assign bus.hour  = hour_v;
  assign bus.min   = min_v;
  assign bus.sec   = sec_v;
  assign unused_ok = &{1'b0, hour_c, sec_nxt, min_nxt, hour_nxt};
`endif

  always_comb begin
    mode_d = mode_q;
    if (mode_adv) begin
      case (mode_q)
        ST_RUN:   mode_d = ST_SET_H;
        ST_SET_H: mode_d = ST_SET_M;
`ifdef ALARM_EN
        ST_SET_M: mode_d = ST_AL_H;
        ST_AL_H:  mode_d = ST_AL_M;
        ST_AL_M:  mode_d = ST_RUN;
`else
        ST_SET_M: mode_d = ST_RUN;
`endif
        default:  mode_d = ST_RUN;
      endcase
    end
  end

  // Pressing inc restarts the blink phase so the edited field stays visible.
  always_comb begin
    blink_d = blink_q;
    if (inc_ok)            blink_d = 1'b0;
    else if (bus.tick_2hz) blink_d = ~blink_q;
    case (mode_d)
      ST_SET_H, ST_AL_H: mask_d = {blink_d, 2'b00};
      ST_SET_M, ST_AL_M: mask_d = {1'b0, blink_d, 1'b0};
      default:           mask_d = 3'b000;
    endcase
  end

  always_comb begin
    beep_d = beep_q;
    if (alarm_hit)                   beep_d = BEEP_W'(ALARM_SECS);
    else if (chime_hit)              beep_d = BEEP_W'(CHIME_SECS);
    else if (consume)                beep_d = '0;
    else if (bus.tick_1hz && beep_on) beep_d = beep_q - BEEP_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_q  <= ST_RUN;
      blink_q <= 1'b0;
      mask_q  <= 3'b000;
      beep_q  <= '0;
    end else begin
      mode_q  <= mode_d;
      blink_q <= blink_d;
      mask_q  <= mask_d;
      beep_q  <= beep_d;
    end
  end

  assign bus.mode       = mode_q;
  assign bus.blink_mask = mask_q;
  assign bus.beep_en    = beep_on;

endmodule

// File: tb/tb_clock_time_ctrl.sv
// Directed scoreboard bench for clock_time_ctrl; alarm scenarios run when ALARM_EN is defined.
module tb_clock_time_ctrl;

  localparam int CHIME = 2;
  localparam int ALARM = 30;
`ifdef ALARM_EN
  localparam bit HAS_AL = 1'b1;
`else
  localparam bit HAS_AL = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  clock_time_ctrl_if bus();

  clock_time_ctrl #(.CHIME_SECS(CHIME), .ALARM_SECS(ALARM)) dut (
    .clk(clk), .reset(reset), .bus(bus.slave));

  typedef struct {
    string       tag;
    logic [30:0] word;
  } exp_t;

  exp_t  sb[$];
  int    vectors = 0;
  int    miscompares = 0;
  string tag = "init";

  int m_h, m_m, m_s, m_ah, m_am, m_mode, m_beep;
  bit m_ph;

  function automatic logic [7:0] bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  function automatic logic [30:0] model_word();
    logic [2:0] mask;
    bit al;
    mask = 3'b000;
    if (m_mode == 1 || m_mode == 3) mask = {m_ph, 2'b00};
    if (m_mode == 2 || m_mode == 4) mask = {1'b0, m_ph, 1'b0};
    al = (m_mode >= 3);
    return {bcd(al ? m_ah : m_h), bcd(al ? m_am : m_m), al ? 8'h00 : bcd(m_s),
            3'(m_mode), mask, (m_beep != 0)};
  endfunction

  function automatic logic [30:0] obs_word();
    return {bus.hour, bus.min, bus.sec, bus.mode, bus.blink_mask, bus.beep_en};
  endfunction

  task automatic model_reset();
    m_h = 0; m_m = 0; m_s = 0; m_ah = 7; m_am = 0; m_mode = 0; m_beep = 0; m_ph = 1'b0;
  endtask

  task automatic model_step(input bit t1, input bit t2, input bit km, input bit ki);
    bit consume, adv, inc, chime, alarm;
    consume = (km || ki) && (m_beep != 0);
    adv     = km && !consume;
    inc     = ki && !km && !consume;
    chime   = 1'b0;
    alarm   = 1'b0;
    if (t1 && (m_mode == 0 || (HAS_AL && m_mode >= 3))) begin
      m_s = m_s + 1;
      if (m_s == 60) begin
        m_s = 0;
        m_m = m_m + 1;
        if (m_m == 60) begin
          m_m = 0;
          m_h = (m_h + 1) % 24;
          chime = (m_mode == 0);
        end
      end
      alarm = HAS_AL && (m_s == 0) && (m_m == m_am) && (m_h == m_ah);
    end
    if (inc) begin
      case (m_mode)
        1: m_h  = (m_h + 1) % 24;
        2: m_m  = (m_m + 1) % 60;
        3: m_ah = (m_ah + 1) % 24;
        4: m_am = (m_am + 1) % 60;
        default: ;
      endcase
    end
    if (adv) begin
      if (m_mode == 2) m_s = 0;
      case (m_mode)
        0: m_mode = 1;
        1: m_mode = 2;
        2: m_mode = HAS_AL ? 3 : 0;
        3: m_mode = 4;
        default: m_mode = 0;
      endcase
    end
    if (inc)     m_ph = 1'b0;
    else if (t2) m_ph = ~m_ph;
    if (alarm)                  m_beep = ALARM;
    else if (chime)             m_beep = CHIME;
    else if (consume)           m_beep = 0;
    else if (t1 && m_beep != 0) m_beep = m_beep - 1;
  endtask

  task automatic compare(input string name, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h, expected %h", name, obs, exp);
    end
  endtask

  task automatic pop_and_compare();
    exp_t e;
    e = sb.pop_front();
    compare(e.tag, {1'b0, obs_word()}, {1'b0, e.word});
  endtask

  task automatic push_expected();
    exp_t e;
    e.tag  = tag;
    e.word = model_word();
    sb.push_back(e);
  endtask

  task automatic step(input bit t1, input bit t2, input bit km, input bit ki);
    bus.tick_1hz = t1; bus.tick_2hz = t2; bus.key_mode = km; bus.key_inc = ki;
    model_step(t1, t2, km, ki);
    push_expected();
    @(posedge clk);
    #1;
    bus.tick_1hz = 1'b0; bus.tick_2hz = 1'b0; bus.key_mode = 1'b0; bus.key_inc = 1'b0;
    pop_and_compare();
  endtask

  task automatic ticks(input int n);
    repeat (n) step(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic incs(input int n);
    repeat (n) step(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic goto_mode(input int target);
    for (int i = 0; i < 6 && m_mode != target; i++) step(1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic set_time(input int h, input int m);
    goto_mode(1);
    incs((h - m_h + 24) % 24);
    goto_mode(2);
    incs((m - m_m + 60) % 60);
    goto_mode(0);
  endtask

  task automatic set_alarm(input int h, input int m);
    goto_mode(3);
    incs((h - m_ah + 24) % 24);
    goto_mode(4);
    incs((m - m_am + 60) % 60);
    goto_mode(0);
  endtask

  initial begin
    bus.tick_1hz = 1'b0; bus.tick_2hz = 1'b0; bus.key_mode = 1'b0; bus.key_inc = 1'b0;
    reset = 1'b1;
    model_reset();
    #2;
    tag = "reset";
    push_expected();
    pop_and_compare();
    @(negedge clk);
    reset = 1'b0;

    tag = "run3";
    ticks(3);
    compare("run3_time", {8'h0, bus.hour, bus.min, bus.sec}, 32'h0000_0003);
    compare("run3_ctrl", {25'h0, bus.mode, bus.blink_mask, bus.beep_en}, 32'h0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    compare("run_mask", {29'h0, bus.blink_mask}, 32'h0);

    tag = "rollover";
    set_time(23, 59);
    ticks(58);
    compare("preset", {8'h0, bus.hour, bus.min, bus.sec}, 32'h0023_5958);
    ticks(1);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    ticks(1);
    compare("wrap_time", {8'h0, bus.hour, bus.min, bus.sec}, 32'h0);
    compare("chime_on", {31'h0, bus.beep_en}, 32'h1);
    ticks(1);
    compare("chime_1", {31'h0, bus.beep_en}, 32'h1);
    ticks(1);
    compare("chime_off", {31'h0, bus.beep_en}, 32'h0);

    tag = "set";
    goto_mode(1);
    goto_mode(2);
    goto_mode(0);
    compare("sec_cleared", {24'h0, bus.sec}, 32'h0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    incs(5);
    compare("set_h5", {21'h0, bus.hour, bus.mode}, {21'h0, 8'h05, 3'd1});
    compare("set_h_mask0", {29'h0, bus.blink_mask}, 32'h0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    compare("set_h_blink", {29'h0, bus.blink_mask}, 32'h4);
    ticks(3);
    compare("frozen", {8'h0, bus.hour, bus.min, bus.sec}, 32'h0005_0000);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    compare("inc_shows", {21'h0, bus.hour, bus.blink_mask}, {21'h0, 8'h06, 3'b000});
    step(1'b0, 1'b0, 1'b1, 1'b0);
    compare("set_m", {21'h0, bus.sec, bus.mode}, {21'h0, 8'h00, 3'd2});
    step(1'b0, 1'b1, 1'b0, 1'b0);
    compare("set_m_blink", {29'h0, bus.blink_mask}, 32'h2);
    goto_mode(0);

    tag = "mode_and_inc";
    step(1'b0, 1'b0, 1'b1, 1'b1);
    compare("mode_wins", {21'h0, bus.hour, bus.mode}, {21'h0, 8'h06, 3'd1});
    goto_mode(0);

    tag = "consume";
    set_time(5, 59);
    ticks(60);
    compare("chime_06", {15'h0, bus.hour, bus.min, bus.beep_en}, {15'h0, 8'h06, 8'h00, 1'b1});
    step(1'b0, 1'b0, 1'b0, 1'b1);
    compare("consumed", {20'h0, bus.hour, bus.mode, bus.beep_en}, {20'h0, 8'h06, 3'd0, 1'b0});
    step(1'b0, 1'b0, 1'b1, 1'b0);
    goto_mode(0);

    tag = "reset_mid";
    set_time(8, 59);
    ticks(60);
    compare("chime_09", {31'h0, bus.beep_en}, 32'h1);
    #1;
    reset = 1'b1;
    model_reset();
    #1;
    push_expected();
    pop_and_compare();
    compare("reset_outs", {1'b0, obs_word()}, 32'h0);
    @(negedge clk);
    reset = 1'b0;

`ifdef ALARM_EN
    tag = "alarm";
    goto_mode(3);
    compare("al_show", {8'h0, bus.hour, bus.min, bus.sec}, 32'h0007_0000);
    goto_mode(0);
    set_alarm(7, 1);
    set_time(7, 0);
    ticks(59);
    compare("pre_alarm", {31'h0, bus.beep_en}, 32'h0);
    ticks(1);
    compare("alarm_on", {31'h0, bus.beep_en}, 32'h1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    compare("alarm_silenced", {31'h0, bus.beep_en}, 32'h0);
    goto_mode(4);
    compare("al_min_kept", {24'h0, bus.min}, 32'h01);
    goto_mode(0);

    tag = "alarm_vs_chime";
    set_alarm(8, 0);
    set_time(7, 59);
    ticks(60);
    compare("both_hit", {15'h0, bus.hour, bus.min, bus.beep_en}, {15'h0, 8'h08, 8'h00, 1'b1});
    ticks(ALARM - 1);
    compare("alarm_last", {31'h0, bus.beep_en}, 32'h1);
    ticks(1);
    compare("alarm_done", {31'h0, bus.beep_en}, 32'h0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/clock_time_ctrl.md
# clock_time_ctrl

Time-keeping and setting controller for the 24-hour clock. It consumes the single-cycle tick enables from the time divider and keeps an HH:MM:SS BCD count. A key-driven mode state machine sequences time (and optionally alarm) setting. It also schedules the beep resource between the hourly chime and the alarm, and drives the blink mask for the display scanner.

## Interface
Parameters:
- CHIME_SECS, 2: beep duration in seconds for the hourly chime.
- ALARM_SECS, 30: beep duration in seconds for the alarm.

Ports:
- clk  in  1  system clock; the only clock.
- reset  in  1  asynchronous, active-high reset.
- tick_1hz  in  1  one-cycle pulse once per second, synchronous to clk.
- tick_2hz  in  1  one-cycle pulse twice per second, synchronous to clk.
- key_mode  in  1  debounced one-cycle press pulse; advances the mode.
- key_inc  in  1  debounced one-cycle press pulse; increments the selected field.
- hour  out  8  BCD hours, {tens, ones}, 00..23.
- min  out  8  BCD minutes, 00..59.
- sec  out  8  BCD seconds, 00..59.
- mode  out  3  current FSM state code.
- blink_mask  out  3  fields to blank: [2] hour, [1] minute, [0] second.
- beep_en  out  1  high while the beeper is driven.

## Operation
- FSM states and codes:
  - RUN = 0, SET_H = 1, SET_M = 2, AL_H = 3, AL_M = 4.
- Transitions on key_mode:
  - RUN -> SET_H -> SET_M -> AL_H -> AL_M -> RUN.
  - Without the alarm feature, SET_M -> RUN.
  - No other transitions exist.
- RUN:
  - On tick_1hz, sec increments; 59 -> 00 carries into min.
  - min 59 -> 00 carries into hour; hour 23 -> 00 wraps.
- SET_H and SET_M:
  - The time count is frozen; tick_1hz is ignored for counting.
  - key_inc increments the selected field modulo 24 (hour) or 60 (min), with no carry.
  - Leaving SET_M clears sec to 00.
- AL_H and AL_M:
  - The time keeps running exactly as in RUN.
  - hour/min outputs show the alarm registers al_hour/al_min; sec shows 00.
  - key_inc increments the alarm field modulo 24 or 60.
- Blink:
  - blink_phase toggles on each tick_2hz.
  - The edited field's mask bit equals blink_phase; all other bits are 0.
  - In RUN, blink_mask = 000.
  - key_inc clears blink_phase, so the field is shown while pressing.
- Beep scheduler:
  - beep_cnt counts down on tick_1hz while nonzero; beep_en = (beep_cnt != 0).
  - Chime: in RUN, a tick_1hz that wraps min:sec to 00:00 loads CHIME_SECS.
  - Alarm: a tick_1hz that produces time == al_hour:al_min:00 loads ALARM_SECS.
  - Triggers are evaluated only on tick-driven updates, never on reset or on setting.
- Boundary rules:
  - Chime and alarm in the same cycle: ALARM_SECS loads (alarm has priority).
  - A load and a decrement in the same cycle: the load wins.
  - Any key pulse while beep_en is high clears beep_cnt and is consumed, with no mode or field change.
  - key_mode and key_inc in the same cycle: key_mode wins and key_inc is dropped.
  - reset mid-operation returns every register to its reset value immediately (asynchronous).

## Timing
- Reset values:
  - mode = RUN; hour, min, sec = 00; al_hour:al_min = 07:00.
  - blink_mask = 000; blink_phase = 0; beep_cnt = 0 so beep_en = 0.
- Latency: all outputs are registered and update on the clk edge after the sampled pulse (1 cycle).
- Inputs are level-sampled each cycle; a pulse longer than one cycle counts once per cycle held.
- beep_en rises in the same cycle as the rollover that triggers it.

## Configuration
- ALARM_EN defined:
  - AL_H/AL_M states, alarm registers and alarm trigger are present.
- ALARM_EN undefined:
  - The FSM has 3 states and the beep scheduler serves the chime only.
  - ALARM_SECS is unused.
  - Ports are unchanged; mode never exceeds 2.

## Structure
- Package clock_time_pkg holds:
  - the state enum and codes;
  - BCD modulus constants MOD_HOUR = 24 and MOD_MIN_SEC = 60;
  - defaults for CHIME_SECS and ALARM_SECS.
- Sub-module bcd_mod_counter: parameterised modulus, inc enable, synchronous clear, carry out, 8-bit BCD value.
  - Instantiated for sec, min and hour, plus al_hour and al_min under ALARM_EN.

## Test plan
- Reset, then 3 tick_1hz -> 00:00:03; mode = 0; blink_mask = 000; beep_en = 0.
- Preset 23:59:58, then 2 tick_1hz -> 00:00:00; beep_en high for exactly 2 further tick_1hz.
- key_mode, then 5 key_inc -> mode = 1, hour = 05, time frozen across ticks; key_mode -> mode = 2, sec = 00.
- ALARM_EN: set alarm to 07:01, run from 07:00:59 -> beep_en high; key_inc during beep -> beep_en low next cycle, al_min unchanged.
- ALARM_EN: alarm at 08:00, reach 08:00:00 -> beep lasts ALARM_SECS = 30 ticks (alarm beats chime).
- key_mode and key_inc in the same cycle in RUN -> mode = 1, hour unchanged; assert reset mid-beep -> all outputs reset the same cycle.
